fp_operand_pairer: RTL
======================

FP_OPERAND_PAIRER -- requirements
Module: fp_operand_pairer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning per-operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning IEEE-754 single operand width.
REQ-003 SHALL have port clkIn  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstIn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flushIn  input  1  synchronous clear of all buffered operands.
REQ-006 SHALL have port dataAIn  input  DATA_WIDTH  operand A stream data.
REQ-007 SHALL have port validAIn  input  1  operand A valid.
REQ-008 SHALL have port readyAOut  output  1  operand A accepted when high with validAIn.
REQ-009 SHALL have port dataBIn  input  DATA_WIDTH  operand B stream data.
REQ-010 SHALL have port validBIn  input  1  operand B valid.
REQ-011 SHALL have port readyBOut  output  1  operand B accepted when high with validBIn.
REQ-012 SHALL have port dataAOut  output  DATA_WIDTH  paired A operand to floating_point_add dataAIn.
REQ-013 SHALL have port dataBOut  output  DATA_WIDTH  paired B operand to floating_point_add dataBIn.
REQ-014 SHALL have port validOut  output  1  pair valid, to floating_point_add validIn.
REQ-015 SHALL have port readyIn  input  1  downstream accept; tie high when driving floating_point_add.

Function
REQ-016 SHALL buffer A and B in independent FIFOs of DEPTH entries; A and B streams are never reordered.
REQ-017 SHALL drive readyAOut = A FIFO not full and readyBOut = B FIFO not full, combinationally from occupancy only.
REQ-018 SHALL write A on cycle where validAIn && readyAOut && !flushIn; likewise for B.
REQ-019 SHALL provide no write-through: a write into a full FIFO is refused even if a read occurs the same cycle.
REQ-020 SHALL load the output register (pop one A and one B) when both FIFOs non-empty && (!validOut || readyIn).
REQ-021 SHALL hold dataAOut, dataBOut, validOut stable while validOut && !readyIn.
REQ-022 SHALL clear validOut on a handshake (validOut && readyIn) when no new pair is loaded that cycle.
REQ-023 SHALL have latency 2 cycles: A and B written in cycle N into empty FIFOs -> validOut high in cycle N+2.
REQ-024 SHALL sustain one pair per cycle with readyIn held high and both inputs streaming.
REQ-025 SHALL support simultaneous write and pop on the same FIFO; occupancy unchanged.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1, range 0..DEPTH.
REQ-027 SHALL on flushIn empty both FIFOs and clear validOut next edge; flush has priority over writes and pops.
REQ-028 SHALL pass data bits unmodified (no NaN/denormal handling).

Reset
REQ-029 SHALL, while rstIn low, immediately force validOut=0, dataAOut=0, dataBOut=0, both FIFOs empty, pointers 0.
REQ-030 SHALL drive readyAOut=readyBOut=0 while rstIn low, and 1 from the first edge after release.
REQ-031 SHALL discard all buffered operands on reset asserted mid-operation; no partial pair is emitted after release.

Configuration
REQ-032 SHALL, with macro FP_PAIR_COUNT_EN defined, add port pairCountOut  output  16  count of output handshakes.
REQ-033 SHALL with FP_PAIR_COUNT_EN increment pairCountOut per handshake, wrap 16'hFFFF->0, reset to 0, unaffected by flushIn.
REQ-034 SHALL without FP_PAIR_COUNT_EN omit the port and counter entirely; all other behaviour identical.

Structure
REQ-035 SHALL take FP_WIDTH=32 and typedef fp32_t from shared package fp_pkg, used by floating_point_add too.
REQ-036 SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; full/empty/push/pop/flush) twice, A and B.

Verification
REQ-037 SHALL check: A=0x3F800000, B=0x40000000 in cycle 12 after reset, readyIn=1 -> validOut in cycle 14, outputs 0x3F800000/0x40000000, one cycle.
REQ-038 SHALL check: 4 A words, no B, DEPTH=4 -> readyAOut=0 after 4th write, validOut stays 0; then 4 B words -> 4 pairs in order.
REQ-039 SHALL check: readyIn=0 for 5 cycles with pair 0x41200000/0xC1200000 valid -> outputs held, then released exactly once.
REQ-040 SHALL check: 100 paired writes back-to-back, readyIn=1 -> 100 consecutive validOut cycles, pairCountOut=100 (FP_PAIR_COUNT_EN).
REQ-041 SHALL check: flushIn with 3 A and 2 B buffered and validOut high -> validOut=0, both readies 1, next pair emitted is post-flush data.
REQ-042 SHALL check: rstIn low asynchronously mid-stream between edges -> validOut drops immediately; no stale pair after release.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared single-precision definitions for the floating-point datapath. Both
// the operand pairer and floating_point_add import this package so the operand
// width and type stay in one place.
//
// Contents:
//   FP_WIDTH      - IEEE-754 single-precision word width (32)
//   fp32_t        - raw single-precision word (bits are never interpreted here)
//   PAIR_CNT_W    - width of the optional pair handshake counter
//   fp_ptr_width  - pointer width for a power-of-two buffer depth
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int PAIR_CNT_W = 16;

    typedef logic [FP_WIDTH-1:0] fp32_t;

    // A depth-1 buffer would otherwise give a zero-width pointer.
    function automatic int fp_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : fp_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a show-ahead read port. The
// head entry is presented on rdata_o whenever empty_o is low; pop_i consumes
// it on the next rising edge.
//
// Parameters:
//   WIDTH  - entry width
//   DEPTH  - number of entries (power of two, >= 2)
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset (pointers and occupancy cleared)
//   flush_i  - synchronous clear; overrides push_i and pop_i
//   push_i   - write wdata_i (ignored while full)
//   wdata_i  - write data
//   pop_i    - consume the head entry (ignored while empty)
//   rdata_o  - head entry
//   full_o   - occupancy == DEPTH
//   empty_o  - occupancy == 0
// -----------------------------------------------------------------------------
module sync_fifo
    import fp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = fp_ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a write even when the same edge pops an entry.
    assign push_ok = push_i && !full_o  && !flush_i;
    assign pop_ok  = pop_i  && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only visible once the occupancy
    // counter says it was written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : sync_fifo

// File: rtl/fp_operand_pairer.sv
// -----------------------------------------------------------------------------
// fp_operand_pairer
// Collects the A and B operand streams of floating_point_add into independent
// FIFOs and emits them as registered pairs. A pair leaves only when both
// FIFOs hold data; streams are never reordered and data passes bit-exact.
//
// Parameters:
//   DEPTH       - entries per operand FIFO (power of two, >= 2)
//   DATA_WIDTH  - operand width (single precision, 32)
//
// Ports:
//   clkIn        - clock, rising edge
//   rstIn        - asynchronous active-low reset
//   flushIn      - synchronous clear of both FIFOs and the output pair
//   dataAIn / validAIn / readyAOut - operand A stream
//   dataBIn / validBIn / readyBOut - operand B stream
//   dataAOut / dataBOut / validOut - paired output (to floating_point_add)
//   readyIn      - downstream accept
//   pairCountOut - output handshake count, wraps at 16 bits
//                  (present only when FP_PAIR_COUNT_EN is defined)
//
// Optional feature macro: FP_PAIR_COUNT_EN
// -----------------------------------------------------------------------------
module fp_operand_pairer
    import fp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = FP_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  flushIn,
    input  logic [DATA_WIDTH-1:0] dataAIn,
    input  logic                  validAIn,
    output logic                  readyAOut,
    input  logic [DATA_WIDTH-1:0] dataBIn,
    input  logic                  validBIn,
    output logic                  readyBOut,
    output logic [DATA_WIDTH-1:0] dataAOut,
    output logic [DATA_WIDTH-1:0] dataBOut,
    output logic                  validOut,
    input  logic                  readyIn
`ifdef FP_PAIR_COUNT_EN
    ,
    output logic [PAIR_CNT_W-1:0] pairCountOut
`endif
);

    logic                  a_full, a_empty;
    logic                  b_full, b_empty;
    logic [DATA_WIDTH-1:0] a_head, b_head;
    logic                  a_push, b_push;
    logic                  load_pair;

    logic                  accept_en_q;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;

    // Readies are held low during reset and rise on the first edge after
    // release; otherwise they depend on occupancy only.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            accept_en_q <= 1'b0;
        end else begin
            accept_en_q <= 1'b1;
        end
    end

    assign readyAOut = accept_en_q && !a_full;
    assign readyBOut = accept_en_q && !b_full;

    assign a_push = validAIn && readyAOut && !flushIn;
    assign b_push = validBIn && readyBOut && !flushIn;

    // Refill the output register when it is empty or being drained this edge.
    assign load_pair = !a_empty && !b_empty && (!valid_q || readyIn) && !flushIn;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk_i   (clkIn),
        .rst_ni  (rstIn),
        .flush_i (flushIn),
        .push_i  (a_push),
        .wdata_i (dataAIn),
        .pop_i   (load_pair),
        .rdata_o (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk_i   (clkIn),
        .rst_ni  (rstIn),
        .flush_i (flushIn),
        .push_i  (b_push),
        .wdata_i (dataBIn),
        .pop_i   (load_pair),
        .rdata_o (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    // Output pair register: flush wins, then a fresh pair, then a drain.
    always_comb begin
        valid_d  = valid_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (flushIn) begin
            valid_d = 1'b0;
        end else if (load_pair) begin
            valid_d  = 1'b1;
            data_a_d = a_head;
            data_b_d = b_head;
        end else if (valid_q && readyIn) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            valid_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign validOut = valid_q;
    assign dataAOut = data_a_q;
    assign dataBOut = data_b_q;

`ifdef FP_PAIR_COUNT_EN
    logic [PAIR_CNT_W-1:0] pair_cnt_q, pair_cnt_d;

    // Counts every completed output handshake, flush included; wraps freely.
    assign pair_cnt_d = pair_cnt_q + 1'b1;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            pair_cnt_q <= '0;
        end else if (valid_q && readyIn) begin
            pair_cnt_q <= pair_cnt_d;
        end
    end

    assign pairCountOut = pair_cnt_q;
`endif

endmodule : fp_operand_pairer
